data_mem_lsu: RTL and testbench
===============================

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the number of word-address bits (depth = 2**ADDR_WIDTH words).
REQ-002 The block SHALL have parameter INIT_FILE, default "", a hex preload file, applied only when non-empty.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 Port req_valid  input  1  request present.
REQ-005 Port req_ready  output  1  block can accept a request this cycle.
REQ-006 Port req_we  input  1  1 = store, 0 = load.
REQ-007 Port req_funct3  input  3  RV32I load/store funct3 (size and sign).
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data, right-aligned.
REQ-010 Port resp_valid  output  1  one-cycle response strobe.
REQ-011 Port resp_rdata  output  32  load result, aligned and extended.
REQ-012 Port resp_err  output  1  request rejected (misaligned, out of range or illegal funct3).

Function
REQ-013 Storage SHALL be 2**ADDR_WIDTH words x 32 bits, with independent write enables for each of the four byte lanes.
REQ-014 Word index SHALL be req_addr[ADDR_WIDTH+1:2], and lane SHALL be req_addr[1:0].
REQ-015 A request SHALL be out of range when req_addr[31:ADDR_WIDTH+2] is non-zero.
REQ-016 The FSM SHALL have states IDLE and BUSY, and req_ready SHALL be 1 in IDLE and 0 in BUSY.
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1, req_ready=1 and rst=0; IDLE->BUSY on acceptance, else stay in IDLE.
REQ-018 BUSY SHALL last exactly one cycle: resp_valid=1 for that cycle, then BUSY->IDLE on the next edge; throughput is one request per 2 cycles.
REQ-019 Inputs not sampled at acceptance SHALL be ignored; req_* SHALL be captured at acceptance and may change afterwards.
REQ-020 Legal load funct3 SHALL be 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal store funct3 SHALL be 000 SB, 001 SH, 010 SW; all others are illegal.
REQ-021 Misalignment SHALL be: halfword with addr[0]=1; word with addr[1:0]!=00; bytes are never misaligned.
REQ-022 An erroneous request SHALL perform no memory write and SHALL respond with resp_err=1 and resp_rdata=0.
REQ-023 A store SHALL write byte wdata[7:0] to lane addr[1:0], halfword wdata[15:0] to lanes {addr[1],0}+1:{addr[1],0}, and word to all lanes; other lanes are unchanged.
REQ-024 A store write SHALL occur at the acceptance edge; a store response SHALL have resp_rdata=0 and resp_err=0.
REQ-025 A load SHALL return the selected byte or halfword in bits [7:0]/[15:0], sign-extended for LB/LH and zero-extended for LBU/LHU; LW returns the word unchanged.
REQ-026 A load SHALL observe every store accepted before it (read-after-write via the 2-cycle spacing; no bypass needed).
REQ-027 resp_rdata and resp_err SHALL be registered, valid only while resp_valid=1, and SHALL hold their last value otherwise.

Reset
REQ-028 On rst=1 at a rising edge, the state SHALL become IDLE and resp_valid, resp_rdata and resp_err SHALL become 0.
REQ-029 While rst=1, no request SHALL be accepted and no memory write SHALL occur; memory contents SHALL NOT be cleared.
REQ-030 rst asserted while in BUSY SHALL suppress that response: resp_valid stays 0 and the transaction is dropped.
REQ-031 If INIT_FILE is empty, contents SHALL be undefined until written.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10 -> second response resp_rdata=0xDEADBEEF, resp_err=0, resp_valid one cycle after each acceptance.
REQ-033 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; then LBU @0x13 -> 0x00000080; then LW @0x10 -> 0x80ADBEEF.
REQ-034 SH 0x1234 @0x21 -> resp_err=1, rdata=0; then LW @0x20 -> unchanged prior value; LW @0x22 -> resp_err=1.
REQ-035 With ADDR_WIDTH=10, LW @0x00001000 -> resp_err=1; funct3=011 load @0x0 -> resp_err=1; funct3=100 store -> resp_err=1, no write.
REQ-036 Back-to-back req_valid held high -> req_ready toggles 1,0,1,0, and exactly one resp_valid per accepted request.
REQ-037 Accept SW, then assert rst in the BUSY cycle -> no resp_valid, outputs 0, state IDLE; a following LW @ the same address returns the stored word (write committed at acceptance).

Source files
------------

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with an RV32I load/store front end.
// Takes one request per two cycles and answers with a one-cycle response strobe.
module data_mem_lsu #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter string       INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state;

   logic [31:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            lane;
   logic                  out_of_range;
   logic                  legal;
   logic                  misaligned;
   logic                  req_err;
   logic                  accept;
   logic [3:0]            byte_en;
   logic [31:0]           wr_data;
   logic [31:0]           rd_word;
   logic [31:0]           rd_shift;
   logic [31:0]           load_data;

   assign word_idx     = req_addr[ADDR_WIDTH+1:2];
   assign lane         = req_addr[1:0];
   assign out_of_range = |req_addr[31:ADDR_WIDTH+2];
   assign accept       = req_valid && req_ready && !rst;

   // funct3 legality and alignment; unsigned variants exist only for loads
   always_comb begin
      legal      = 1'b0;
      misaligned = 1'b0;
      case (req_funct3)
         3'b000:         legal = 1'b1;
         3'b001: begin
            legal      = 1'b1;
            misaligned = req_addr[0];
         end
         3'b010: begin
            legal      = 1'b1;
            misaligned = |req_addr[1:0];
         end
         3'b100, 3'b101: begin
            legal      = !req_we;
            misaligned = req_funct3[0] & req_addr[0];
         end
         default:        legal = 1'b0;
      endcase
      req_err = !legal || misaligned || out_of_range;
   end

   // store lane enables with the data replicated across lanes
   always_comb begin
      byte_en = 4'hF;
      wr_data = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            byte_en = 4'b0001 << lane;
            wr_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            byte_en = 4'b0011 << {lane[1], 1'b0};
            wr_data = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // load path: shift the addressed lane down, then extend
   always_comb begin
      rd_word  = mem[word_idx];
      rd_shift = rd_word >> {lane, 3'b000};
      case (req_funct3)
         3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  load_data = {24'b0, rd_shift[7:0]};
         3'b101:  load_data = {16'b0, rd_shift[15:0]};
         default: load_data = rd_word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept && req_we && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= BUSY;
                  req_ready  <= 1'b0;
                  resp_err   <= req_err;
                  resp_rdata <= (req_err || req_we) ? 32'h0 : load_data;
               end
            end
            BUSY: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   // reset during the response cycle drops the response immediately
   assign resp_valid = (state == BUSY) && !rst;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: expected responses are queued at issue
// and checked against the response strobe by a monitor.
module tb_data_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int vectors     = 0;
   int miscompares = 0;
   int resp_seen   = 0;
   int exp_accepts = 0;

   logic [32:0] exp_q [$];

   data_mem_lsu #(.ADDR_WIDTH(10), .INIT_FILE("")) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // response monitor: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         logic [32:0] e;
         resp_seen++;
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'(resp_valid), 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e[31:0]);
            chk("resp_err", 32'(resp_err), 32'(e[32]));
         end
      end
   end

   // issue one request, wait for acceptance, then scramble the inputs
   task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic err, input logic [31:0] rdata);
      int n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(req_ready), 32'h1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      exp_q.push_back({err, rdata});
      exp_accepts++;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      @(negedge clk);
      chk({tag, "_valid"}, 32'(resp_valid), 32'h1);
      chk({tag, "_busy"}, 32'(req_ready), 32'h0);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(resp_valid), 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", 32'(resp_err), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h1);
      rst = 1'b0;

      issue("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      issue("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'h0);
      chk("hold_rdata", resp_rdata, 32'hDEADBEEF);

      issue("sb_13", 1'b1, 3'b000, 32'h13, 32'h12345680, 1'b0, 32'h0);
      issue("lb_13", 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
      issue("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000080);
      issue("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF);

      issue("sw_20", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0);
      issue("sh_21", 1'b1, 3'b001, 32'h21, 32'h00001234, 1'b1, 32'h0);
      issue("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D);
      issue("lw_22", 1'b0, 3'b010, 32'h22, 32'h0, 1'b1, 32'h0);

      issue("sh_22", 1'b1, 3'b001, 32'h22, 32'hFFFFA5B6, 1'b0, 32'h0);
      issue("lw_20b", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hA5B6F00D);
      issue("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'hFFFFA5B6);
      issue("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 32'h0000A5B6);
      issue("lh_20", 1'b0, 3'b001, 32'h20, 32'h0, 1'b0, 32'hFFFFF00D);
      issue("lb_21", 1'b0, 3'b000, 32'h21, 32'h0, 1'b0, 32'hFFFFFFF0);
      issue("lbu_20", 1'b0, 3'b100, 32'h20, 32'h0, 1'b0, 32'h0000000D);

      issue("lw_oor", 1'b0, 3'b010, 32'h00001000, 32'h0, 1'b1, 32'h0);
      issue("ld_f011", 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0);
      issue("st_f100", 1'b1, 3'b100, 32'h20, 32'h0, 1'b1, 32'h0);
      issue("lw_20c", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hA5B6F00D);
      issue("sw_oor", 1'b1, 3'b010, 32'h00001010, 32'h0, 1'b1, 32'h0);
      issue("lw_10c", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF);
      issue("sw_top", 1'b1, 3'b010, 32'hFFC, 32'h11223344, 1'b0, 32'h0);
      issue("lw_top", 1'b0, 3'b010, 32'hFFC, 32'h0, 1'b0, 32'h11223344);

      // back-to-back: valid held high across two acceptances
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      exp_q.push_back({1'b0, 32'h80ADBEEF});
      exp_q.push_back({1'b0, 32'h80ADBEEF});
      exp_accepts += 2;
      for (int i = 0; i < 4; i++) begin
         chk("b2b_ready", 32'(req_ready), 32'((i % 2) == 0));
         @(negedge clk);
      end
      req_valid = 1'b0;

      // reset in the BUSY cycle of a store: response dropped, write kept
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h30;
      req_wdata  = 32'h5A5A5A5A;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      chk("rstbusy_valid", 32'(resp_valid), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstbusy_valid2", 32'(resp_valid), 32'h0);
      chk("rstbusy_ready", 32'(req_ready), 32'h1);
      chk("rstbusy_err", 32'(resp_err), 32'h0);
      issue("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'h5A5A5A5A);

      // reset in the BUSY cycle of a load clears the held read data
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      chk("rstld_valid", 32'(resp_valid), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstld_rdata", resp_rdata, 32'h0);
      chk("rstld_valid2", 32'(resp_valid), 32'h0);

      repeat (2) @(negedge clk);
      chk("resp_count", 32'(resp_seen), 32'(exp_accepts));
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
